// File: rtl/devb_arb_pkg.sv
// Shared types and constants for the DeviceB round-robin arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package devb_arb_pkg;

    localparam int DEVB_DW    = 64;
    localparam int DEVB_BEATS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } devb_arb_state_t;

endpackage

// File: rtl/devb_rr_pick.sv
// Round-robin pick between two requesters; a tie goes to the one not served last.
// Latency: purely combinational.
// Backpressure: none; the caller samples the result only while idle.
// Ports: readyA0/readyA1 requests, last = index served last,
//        req_any = any request present, pick = index to grant.
module devb_rr_pick
    import devb_arb_pkg::*;
(
    input  logic readyA0,
    input  logic readyA1,
    input  logic last,
    output logic req_any,
    output logic pick
);

    assign req_any = readyA0 | readyA1;
    // A lone requester wins outright; on a tie the previous winner yields.
    assign pick    = (readyA0 && readyA1) ? ~last : readyA1;

endmodule

// File: rtl/devb_rr_arbiter.sv
// Shares one DeviceB 64-to-4x16 serializer between two producers, round-robin.
// Latency: request in IDLE at N -> readyA at N+1; grant held until the last beat reaches DeviceC.
// Backpressure: grant held until acceptedB, then until BEATS readyB&&acceptedC beats; new requests wait in IDLE.
// Ports: clk, rst_n (async, active-low); readyA0/1 + in_A0/1 from producers;
//        acceptedB, readyB, acceptedC from DeviceB side (C handshake observed only);
//        readyA, in_B to DeviceB; acceptedA0/1 to producers; owner, busy status.
// Optional: DEVB_ARB_STATS_EN adds saturating per-producer transaction counters cnt_A0/cnt_A1.
module devb_rr_arbiter
    import devb_arb_pkg::*;
#(
    parameter int DW     = DEVB_DW,
    parameter int BEATS  = DEVB_BEATS,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              readyA0,
    input  logic              readyA1,
    input  logic [DW-1:0]     in_A0,
    input  logic [DW-1:0]     in_A1,
    input  logic              acceptedB,
    input  logic              readyB,
    input  logic              acceptedC,
    output logic              readyA,
    output logic [DW-1:0]     in_B,
    output logic              acceptedA0,
    output logic              acceptedA1,
    output logic              owner,
    output logic              busy
`ifdef DEVB_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] cnt_A0,
    output logic [STAT_W-1:0] cnt_A1
`endif
);

    localparam int             BW        = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0]  LAST_BEAT = BW'(BEATS - 1);

    devb_arb_state_t state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_q, last_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [DW-1:0]   word_q;
    logic            req_any, pick;
    logic            beat_ok, drain_done, load_word;

    devb_rr_pick u_pick (
        .readyA0 (readyA0),
        .readyA1 (readyA1),
        .last    (last_q),
        .req_any (req_any),
        .pick    (pick)
    );

    // acceptedC alone is not a beat; DeviceB must be presenting one.
    assign beat_ok    = readyB && acceptedC;
    assign drain_done = (state_q == DRAIN) && beat_ok && (beat_q == LAST_BEAT);
    assign load_word  = (state_q == GRANT) && acceptedB;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    owner_d = pick;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // No abort path: a dropped request still waits for acceptedB.
                if (acceptedB) begin
                    beat_d  = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (beat_ok) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        last_d  = owner_q;
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
        end
    end

    // The producer may drop or replace its word right after its acknowledge,
    // so the accepted word is held locally for the whole drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
        end else if (load_word) begin
            word_q <= owner_q ? in_A1 : in_A0;
        end
    end

    assign readyA     = (state_q == GRANT);
    assign busy       = (state_q != IDLE);
    assign owner      = owner_q;
    assign in_B       = (state_q == DRAIN) ? word_q : (owner_q ? in_A1 : in_A0);
    assign acceptedA0 = load_word && !owner_q;
    assign acceptedA1 = load_word &&  owner_q;

`ifdef DEVB_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_A0 <= '0;
            cnt_A1 <= '0;
        end else if (drain_done) begin
            // Saturate rather than wrap so a stuck-high count stays visible.
            if (!owner_q && (cnt_A0 != '1)) cnt_A0 <= cnt_A0 + STAT_W'(1);
            if ( owner_q && (cnt_A1 != '1)) cnt_A1 <= cnt_A1 + STAT_W'(1);
        end
    end
`else
    // STAT_W only sizes the optional counters; keep it referenced here.
    logic [STAT_W-1:0] unused_stat_w;
    logic              unused_drain_done;
    assign unused_stat_w     = '0;
    assign unused_drain_done = drain_done;
`endif

endmodule

// File: tb/tb_devb_rr_arbiter.sv
// Bench for devb_rr_arbiter with a cycle-level DeviceB/DeviceC model and two producers.
// Expected grants (owner, word) are queued when requests are posted and checked on acknowledge.
module tb_devb_rr_arbiter;

    localparam int DW    = 64;
    localparam int BEATS = 4;
`ifdef DEVB_ARB_STATS_EN
    localparam int SW = 2;
`else
    localparam int SW = 16;
`endif
    localparam logic [DW-1:0] IDLE_A0 = 64'hA0A0_0000_0000_00A0;
    localparam logic [DW-1:0] IDLE_A1 = 64'hA1A1_0000_0000_00A1;

    typedef enum logic [2:0] {MB_IDLE, MB_LOAD, MB_ACC, MB_SEND, MB_GAP} mb_t;
    typedef struct {
        logic          id;
        logic [DW-1:0] word;
    } txn_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          readyA0, readyA1, acceptedB, readyB, acceptedC;
    logic [DW-1:0] in_A0, in_A1;
    logic          readyA, acceptedA0, acceptedA1, owner, busy;
    logic [DW-1:0] in_B;
`ifdef DEVB_ARB_STATS_EN
    logic [SW-1:0] cnt_A0, cnt_A1;
`endif

    always #5 clk = ~clk;

    devb_rr_arbiter #(.DW(DW), .BEATS(BEATS), .STAT_W(SW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .readyA0    (readyA0),
        .readyA1    (readyA1),
        .in_A0      (in_A0),
        .in_A1      (in_A1),
        .acceptedB  (acceptedB),
        .readyB     (readyB),
        .acceptedC  (acceptedC),
        .readyA     (readyA),
        .in_B       (in_B),
        .acceptedA0 (acceptedA0),
        .acceptedA1 (acceptedA1),
        .owner      (owner),
        .busy       (busy)
`ifdef DEVB_ARB_STATS_EN
        ,
        .cnt_A0     (cnt_A0),
        .cnt_A1     (cnt_A1)
`endif
    );

    int            n_chk = 0;
    int            n_err = 0;
    txn_t          exp_q[$];
    logic [DW-1:0] p0_q[$];
    logic [DW-1:0] p1_q[$];
    mb_t           mb;
    logic [DW-1:0] mb_word, cur_word;
    int            beat, wait_c, stall, gap_en, stray_en;
    logic          nx_ab, nx_rb, nx_ac;
    bit            post_final, gap_pend;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_prod();
        readyA0 = (p0_q.size() > 0);
        in_A0   = readyA0 ? p0_q[0] : IDLE_A0;
        readyA1 = (p1_q.size() > 0);
        in_A1   = readyA1 ? p1_q[0] : IDLE_A1;
    endtask

    task automatic post(input logic id, input logic [DW-1:0] w);
        txn_t e;
        e.id = id;
        e.word = w;
        exp_q.push_back(e);
        if (id) p1_q.push_back(w);
        else    p0_q.push_back(w);
    endtask

    task automatic model_clear();
        mb = MB_IDLE; beat = 0; wait_c = 0;
        nx_ab = 0; nx_rb = 0; nx_ac = 0;
        post_final = 0; gap_pend = 0;
        exp_q.delete(); p0_q.delete(); p1_q.delete();
        acceptedB = 0; readyB = 0; acceptedC = 0;
        drive_prod();
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_readyA"}, 64'(readyA), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_acceptedA0"}, 64'(acceptedA0), 64'(0));
        check({tag, "_acceptedA1"}, 64'(acceptedA1), 64'(0));
        check({tag, "_owner"}, 64'(owner), 64'(0));
        check({tag, "_in_B"}, in_B, in_A0);
`ifdef DEVB_ARB_STATS_EN
        check({tag, "_cnt_A0"}, 64'(cnt_A0), 64'(0));
        check({tag, "_cnt_A1"}, 64'(cnt_A1), 64'(0));
`endif
    endtask

    task automatic do_reset(input string tag);
        rst_n = 0;
        model_clear();
        #1;
        chk_reset(tag);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1;
    endtask

    // One clock: sample everything at the falling edge, advance the models,
    // then drive the new input values just after the rising edge.
    task automatic cycle();
        logic          s_ra, s_a0, s_a1, s_rb, s_ac, s_busy, s_own;
        logic [DW-1:0] s_inb;
        txn_t          e;
        @(negedge clk);
        s_ra = readyA; s_a0 = acceptedA0; s_a1 = acceptedA1;
        s_rb = readyB; s_ac = acceptedC; s_busy = busy; s_own = owner; s_inb = in_B;

        if (post_final) begin
            check("drain_exit_busy", 64'(s_busy), 64'(0));
            check("drain_exit_readyA", 64'(s_ra), 64'(0));
            post_final = 0;
            gap_pend = (p0_q.size() + p1_q.size()) > 0;
        end else if (gap_pend) begin
            check("idle_gap_readyA", 64'(s_ra), 64'(1));
            gap_pend = 0;
        end

        if (s_a0 || s_a1) begin
            check("ack_onehot", 64'(s_a0 & s_a1), 64'(0));
            check("ack_expected", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("grant_owner", 64'(s_own), 64'(e.id));
                check("ack_id", 64'(s_a1), 64'(e.id));
                check("grant_word", s_inb, e.word);
                cur_word = e.word;
            end
            if (s_a0 && p0_q.size() > 0) void'(p0_q.pop_front());
            if (s_a1 && p1_q.size() > 0) void'(p1_q.pop_front());
        end

        case (mb)
            MB_IDLE: if (s_ra) mb = MB_LOAD;
            MB_LOAD: begin
                mb_word = s_inb;
                nx_ab = 1;
                mb = MB_ACC;
            end
            MB_ACC: begin
                check("grant_in_B", s_inb, mb_word);
                nx_ab = 0; nx_rb = 1; nx_ac = (stall == 0);
                wait_c = 0; beat = 0;
                mb = MB_SEND;
            end
            MB_SEND: begin
                check("drain_busy", 64'(s_busy), 64'(1));
                check("drain_in_B", s_inb, mb_word);
                if (s_rb && s_ac) begin
                    check("beat_dat", 64'(mb_word[DW-1-16*beat -: 16]), 64'(cur_word[DW-1-16*beat -: 16]));
                    beat++;
                    if (beat == BEATS) begin
                        mb = MB_IDLE; nx_rb = 0; nx_ac = 0; post_final = 1;
                    end else if (gap_en != 0) begin
                        mb = MB_GAP; nx_rb = 0; nx_ac = (stray_en != 0);
                    end else begin
                        wait_c = 0; nx_ac = (stall == 0);
                    end
                end else begin
                    wait_c++;
                    nx_ac = (wait_c >= stall);
                end
            end
            MB_GAP: begin
                check("gap_busy", 64'(s_busy), 64'(1));
                check("gap_in_B", s_inb, mb_word);
                mb = MB_SEND; nx_rb = 1; nx_ac = (stall == 0); wait_c = 0;
            end
            default: mb = MB_IDLE;
        endcase

        @(posedge clk);
        #1;
        acceptedB = nx_ab; readyB = nx_rb; acceptedC = nx_ac;
        drive_prod();
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int  i;
        bit  done;
        i = 0;
        done = 0;
        while (!done && i < 400) begin
            cycle();
            i++;
            done = (exp_q.size() == 0) && (mb == MB_IDLE) && !post_final && !gap_pend &&
                   (p0_q.size() == 0) && (p1_q.size() == 0) && !busy;
        end
        if (!done) check({tag, "_timeout"}, 64'(done), 64'(1));
    endtask

    initial begin
        int i;
        stall = 0; gap_en = 0; stray_en = 0;
        cur_word = '0; mb_word = '0;
        do_reset("rst0");

        // Single requester with cycle-exact grant timing.
        post(1'b0, 64'h1111_2222_3333_4444);
        drive_prod();
        cycle();
        check("s1_readyA_n1", 64'(readyA), 64'(1));
        check("s1_busy_n1", 64'(busy), 64'(1));
        cycle();
        check("s1_ack_n2", 64'(acceptedA0), 64'(0));
        cycle();
        check("s1_ack_n3", 64'(acceptedA0), 64'(1));
        wait_idle("s1");
        check("s1_busy_end", 64'(busy), 64'(0));
        check("s1_owner_end", 64'(owner), 64'(0));

        // Tie straight out of reset: A0 then A1.
        do_reset("rst1");
        post(1'b0, 64'hAAAA_0000_BBBB_0001);
        post(1'b1, 64'hCCCC_1111_DDDD_0002);
        drive_prod();
        wait_idle("tie");
        check("tie_owner_end", 64'(owner), 64'(1));

        // Continuous requests from both: 0,1,0,1 with one idle cycle between.
        post(1'b0, 64'h0A0A_0001_0A0A_0001);
        post(1'b1, 64'h1B1B_0001_1B1B_0001);
        post(1'b0, 64'h0A0A_0002_0A0A_0002);
        post(1'b1, 64'h1B1B_0002_1B1B_0002);
        drive_prod();
        wait_idle("fair");

        // Slow consumer with stray acceptedC pulses while readyB is low.
        stall = 5; gap_en = 1; stray_en = 1;
        post(1'b0, 64'h5555_6666_7777_8888);
        drive_prod();
        wait_idle("slow");
        stall = 0; gap_en = 0; stray_en = 0;

        // Reset after two beats, then a clean A1 transaction.
        do_reset("rst2");
        post(1'b1, 64'h9999_AAAA_BBBB_CCCC);
        drive_prod();
        i = 0;
        while (beat != 2 && i < 100) begin
            cycle();
            i++;
        end
        check("mid_reached_beat2", 64'(beat), 64'(2));
        check("mid_owner_pre", 64'(owner), 64'(1));
        check("mid_busy_pre", 64'(busy), 64'(1));
        do_reset("mid");
        post(1'b1, 64'hDEAD_BEEF_0123_4567);
        drive_prod();
        wait_idle("after_mid");
        check("after_mid_owner", 64'(owner), 64'(1));

`ifdef DEVB_ARB_STATS_EN
        do_reset("rst3");
        for (int k = 1; k <= 5; k++) begin
            post(1'b1, 64'hC0DE_0000_0000_0000 | 64'(k));
            drive_prod();
            wait_idle("stats");
            check("stats_cnt_A1", 64'(cnt_A1), 64'((k < 3) ? k : 3));
            check("stats_cnt_A0", 64'(cnt_A0), 64'(0));
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
